// File: rtl/alu_rs_if.sv
// Bundle of the dispatch, CDB, issue and status signals around the ALU
// reservation station. The slave side is the reservation station itself;
// the master side is whatever drives dispatch/CDB and consumes the issue slot.
interface alu_rs_if #(
    parameter int ROBEN_W = 5,
    parameter int IDX_W   = 4
);
    logic               flush;

    logic               disp_valid;
    logic               disp_ready;
    logic [ROBEN_W-1:0] disp_ROBEN;
    logic [11:0]        disp_opcode;
    logic [3:0]         disp_ALUOP;
    logic [31:0]        disp_Vj;
    logic [31:0]        disp_Vk;
    logic [ROBEN_W-1:0] disp_Qj;
    logic [ROBEN_W-1:0] disp_Qk;

    logic               cdb_valid;
    logic [ROBEN_W-1:0] cdb_ROBEN;
    logic [31:0]        cdb_res;

    logic               fu_free;
    logic               iss_valid;
    logic [ROBEN_W-1:0] iss_ROBEN;
    logic [11:0]        iss_opcode;
    logic [3:0]         iss_ALUOP;
    logic [31:0]        iss_A;
    logic [31:0]        iss_B;

    logic [IDX_W:0]     occupancy;

    modport master (
        output flush,
        output disp_valid, disp_ROBEN, disp_opcode, disp_ALUOP,
        output disp_Vj, disp_Vk, disp_Qj, disp_Qk,
        output cdb_valid, cdb_ROBEN, cdb_res,
        output fu_free,
        input  disp_ready,
        input  iss_valid, iss_ROBEN, iss_opcode, iss_ALUOP, iss_A, iss_B,
        input  occupancy
    );

    modport slave (
        input  flush,
        input  disp_valid, disp_ROBEN, disp_opcode, disp_ALUOP,
        input  disp_Vj, disp_Vk, disp_Qj, disp_Qk,
        input  cdb_valid, cdb_ROBEN, cdb_res,
        input  fu_free,
        output disp_ready,
        output iss_valid, iss_ROBEN, iss_opcode, iss_ALUOP, iss_A, iss_B,
        output occupancy
    );
endinterface

// File: rtl/alu_reservation_station.sv
// Reservation station for the integer ALU. Holds dispatched ALU/branch ops
// until both operands are valid, snoops the CDB for late operands by ROB tag,
// and issues at most one ready op per cycle into registered issue outputs.
// rst is asynchronous and active-low.
module alu_reservation_station #(
    parameter int RS_DEPTH = 16,
    parameter int IDX_W    = 4,
    parameter int ROBEN_W  = 5
) (
    input logic     clk,
    input logic     rst,
    alu_rs_if.slave bus
);

    typedef struct packed {
        logic [ROBEN_W-1:0] roben;
        logic [11:0]        opcode;
        logic [3:0]         aluop;
        logic [31:0]        vj;
        logic [31:0]        vk;
        logic [ROBEN_W-1:0] qj;
        logic [ROBEN_W-1:0] qk;
    } rs_entry_t;

    logic [RS_DEPTH-1:0] busy;
    rs_entry_t           entry [RS_DEPTH];
    rs_entry_t           new_entry;

    logic [IDX_W-1:0]    free_idx;
    logic                any_free;
    logic [IDX_W-1:0]    iss_idx;
    logic                any_ready;
    logic                do_disp;
    logic                do_issue;
    logic [IDX_W:0]      occ;

    logic                iss_valid_q;
    logic [ROBEN_W-1:0]  iss_roben_q;
    logic [11:0]         iss_opcode_q;
    logic [3:0]          iss_aluop_q;
    logic [31:0]         iss_a_q;
    logic [31:0]         iss_b_q;

    // Priority pick of the lowest free slot and the lowest ready slot from registered state.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        free_idx  = '0;
        any_free  = 1'b0;
        iss_idx   = '0;
        any_ready = 1'b0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_idx = IDX_W'(i);
                any_free = 1'b1;
            end
            if (busy[i] && entry[i].qj == '0 && entry[i].qk == '0) begin
                iss_idx   = IDX_W'(i);
                any_ready = 1'b1;
            end
        end
    end

    assign do_disp  = bus.disp_valid && any_free && !bus.flush;
    assign do_issue = bus.fu_free && any_ready && !bus.flush;

    // Dispatched entry, with operands forwarded from a same-cycle CDB broadcast.
    always_comb begin
        new_entry.roben  = bus.disp_ROBEN;
        new_entry.opcode = bus.disp_opcode;
        new_entry.aluop  = bus.disp_ALUOP;
        new_entry.vj     = bus.disp_Vj;
        new_entry.qj     = bus.disp_Qj;
        new_entry.vk     = bus.disp_Vk;
        new_entry.qk     = bus.disp_Qk;
        if (bus.cdb_valid && bus.disp_Qj != '0 && bus.disp_Qj == bus.cdb_ROBEN) begin
            new_entry.vj = bus.cdb_res;
            new_entry.qj = '0;
        end
        if (bus.cdb_valid && bus.disp_Qk != '0 && bus.disp_Qk == bus.cdb_ROBEN) begin
            new_entry.vk = bus.cdb_res;
            new_entry.qk = '0;
        end
    end

    // Slot occupancy flags: flush clears all, issue frees one, dispatch claims one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state is written with <= so every flop samples pre-edge values.
            busy <= '0;
        end else if (bus.flush) begin
            busy <= '0;
        end else begin
            if (do_issue) busy[iss_idx] <= 1'b0;
            if (do_disp)  busy[free_idx] <= 1'b1;
        end
    end

    // Entry payload: write on dispatch, capture CDB values into waiting operands.
    // NOTE: payload is not reset; busy alone says whether an entry's contents mean anything.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (do_disp && free_idx == IDX_W'(i)) begin
                entry[i] <= new_entry;
            end else if (busy[i] && bus.cdb_valid) begin
                if (entry[i].qj != '0 && entry[i].qj == bus.cdb_ROBEN) begin
                    entry[i].vj <= bus.cdb_res;
                    entry[i].qj <= '0;
                end
                if (entry[i].qk != '0 && entry[i].qk == bus.cdb_ROBEN) begin
                    entry[i].vk <= bus.cdb_res;
                    entry[i].qk <= '0;
                end
            end
        end
    end

    // Issue slot: copy the chosen entry, otherwise present a ROBEN-0 bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_valid_q  <= 1'b0;
            iss_roben_q  <= '0;
            iss_opcode_q <= '0;
            iss_aluop_q  <= '0;
            iss_a_q      <= '0;
            iss_b_q      <= '0;
        end else if (do_issue) begin
            iss_valid_q  <= 1'b1;
            iss_roben_q  <= entry[iss_idx].roben;
            iss_opcode_q <= entry[iss_idx].opcode;
            iss_aluop_q  <= entry[iss_idx].aluop;
            iss_a_q      <= entry[iss_idx].vj;
            iss_b_q      <= entry[iss_idx].vk;
        end else begin
            iss_valid_q  <= 1'b0;
            iss_roben_q  <= '0;
            iss_opcode_q <= '0;
        end
    end

    // Occupancy counter tracking dispatches minus issues.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ <= '0;
        end else if (bus.flush) begin
            occ <= '0;
        end else begin
            occ <= occ + (IDX_W+1)'(do_disp) - (IDX_W+1)'(do_issue);
        end
    end

    assign bus.disp_ready = any_free;
    assign bus.occupancy  = occ;
    assign bus.iss_valid  = iss_valid_q;
    assign bus.iss_ROBEN  = iss_roben_q;
    assign bus.iss_opcode = iss_opcode_q;
    assign bus.iss_ALUOP  = iss_aluop_q;
    assign bus.iss_A      = iss_a_q;
    assign bus.iss_B      = iss_b_q;

endmodule
